// File: rtl/drawpoint_pkg.sv
// Shared register map, control bit positions and FSM state types for the
// DrawPoint Avalon-MM bridge.
package drawpoint_pkg;

   localparam logic [15:0] ADDR_VER0   = 16'h0000;
   localparam logic [15:0] ADDR_VER1   = 16'h0001;
   localparam logic [15:0] ADDR_VER2   = 16'h0002;
   localparam logic [15:0] ADDR_VER3   = 16'h0003;
   localparam logic [15:0] ADDR_STATUS = 16'h0004;
   localparam logic [15:0] ADDR_CTRL   = 16'h0005;
   localparam logic [15:0] ADDR_GAP    = 16'h0006;
   localparam logic [15:0] ADDR_POSX   = 16'h0008;
   localparam logic [15:0] ADDR_POSY   = 16'h0009;
   localparam logic [15:0] ADDR_RGB    = 16'h000A;

   localparam int CTRL_ENABLE  = 0;
   localparam int CTRL_AUTOINC = 1;
   localparam int CTRL_FLUSH   = 2;

   typedef enum logic {
      BURST_IDLE,
      BURST_RUN
   } burst_state_t;

   typedef enum logic [1:0] {
      DRAIN_IDLE,
      DRAIN_EMIT,
      DRAIN_HOLD
   } drain_state_t;

endpackage

// File: rtl/drawpoint_fifo.sv
// Synchronous show-ahead FIFO holding staged points; the head entry is
// always visible on pop_data, and flush empties it in a single cycle.
module drawpoint_fifo #(
   parameter int WIDTH = 30,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (level == LW'(DEPTH));
   assign empty    = (level == '0);
   assign do_push  = push && !full && !flush;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Flush shares the reset path so it always beats a same-cycle push.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/drawpoint_mm_bridge.sv
// Avalon-MM command slave that stages points into a FIFO and replays them
// as paced single-cycle update strobes on the DrawPoint master port.
module drawpoint_mm_bridge
   import drawpoint_pkg::*;
#(
   parameter int         POS_W      = 9,
   parameter int         RGB_W      = 12,
   parameter int         FIFO_DEPTH = 16,
   parameter int         X_MAX      = 319,
   parameter int         Y_MAX      = 239,
   parameter logic [7:0] VER_MAJOR  = 8'h02,
   parameter logic [7:0] VER_MINOR  = 8'h00,
   parameter logic [7:0] VER_REV    = 8'h00,
   parameter logic [7:0] VER_BUILD  = 8'h01
) (
   input  logic             csi_cmd_clock_clk,
   input  logic             rsi_cmd_reset_reset,
   input  logic [15:0]      avs_cmd_address,
   input  logic             avs_cmd_read,
   output logic [15:0]      avs_cmd_readdata,
   output logic             avs_cmd_readdatavalid,
   input  logic             avs_cmd_write,
   input  logic [15:0]      avs_cmd_writedata,
   input  logic [1:0]       avs_cmd_byteenable,
   input  logic             avs_cmd_beginbursttransfer,
   input  logic [9:0]       avs_cmd_burstcount,
   output logic             avs_cmd_waitrequest,
   output logic             coe_dpm_ul1Clock,
   output logic             coe_dpm_ul1Reset_n,
   output logic             coe_dpm_ul1Update,
   output logic [POS_W-1:0] coe_dpm_ulPosX,
   output logic [POS_W-1:0] coe_dpm_ulPosY,
   output logic [RGB_W-1:0] coe_dpm_ulRgbData
);

   localparam int ENTRY_W = 2 * POS_W + RGB_W;
   localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;

   logic               ctrl_enable;
   logic               ctrl_autoinc;
   logic [15:0]        gap;
   logic [POS_W-1:0]   pos_x;
   logic [POS_W-1:0]   pos_y;

   logic               wr_fire;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_flush;
   logic               fifo_full;
   logic               fifo_empty;
   logic [LVL_W-1:0]   fifo_level;
   logic [ENTRY_W-1:0] fifo_rd_data;
   logic [31:0]        level_ext;
   logic [7:0]         fill_sat;

   burst_state_t       burst_state;
   burst_state_t       burst_next;
   logic               burst_start;
   logic [15:0]        burst_addr;
   logic [9:0]         burst_left;
   logic               rd_fire;
   logic               rd_gate;
   logic [15:0]        rd_addr;
   logic [15:0]        rd_word;

   drain_state_t       drain_state;
   drain_state_t       drain_next;
   logic [15:0]        hold_cnt;

   logic               unused_be;

   assign unused_be          = avs_cmd_byteenable[1];
   assign coe_dpm_ul1Clock   = csi_cmd_clock_clk;
   assign coe_dpm_ul1Reset_n = ~rsi_cmd_reset_reset;

   assign avs_cmd_waitrequest = avs_cmd_write && (avs_cmd_address == ADDR_RGB) && fifo_full;
   assign wr_fire    = avs_cmd_write && avs_cmd_byteenable[0] && !avs_cmd_waitrequest;
   assign fifo_push  = wr_fire && (avs_cmd_address == ADDR_RGB);
   assign fifo_flush = wr_fire && (avs_cmd_address == ADDR_CTRL) && avs_cmd_writedata[CTRL_FLUSH];

   drawpoint_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (csi_cmd_clock_clk),
      .reset     (rsi_cmd_reset_reset),
      .push      (fifo_push),
      .push_data ({pos_x, pos_y, avs_cmd_writedata[RGB_W-1:0]}),
      .pop       (fifo_pop),
      .flush     (fifo_flush),
      .pop_data  (fifo_rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign level_ext = 32'(fifo_level);
   assign fill_sat  = (level_ext > 32'd255) ? 8'hFF : level_ext[7:0];

   // Writable registers; autoinc advances the raster position after each push.
   always_ff @(posedge csi_cmd_clock_clk) begin
      if (rsi_cmd_reset_reset) begin
         ctrl_enable  <= 1'b0;
         ctrl_autoinc <= 1'b0;
         gap          <= '0;
         pos_x        <= '0;
         pos_y        <= '0;
      end else if (wr_fire) begin
         case (avs_cmd_address)
            ADDR_CTRL: begin
               ctrl_enable  <= avs_cmd_writedata[CTRL_ENABLE];
               ctrl_autoinc <= avs_cmd_writedata[CTRL_AUTOINC];
            end
            ADDR_GAP:  gap   <= avs_cmd_writedata;
            ADDR_POSX: pos_x <= avs_cmd_writedata[POS_W-1:0];
            ADDR_POSY: pos_y <= avs_cmd_writedata[POS_W-1:0];
            ADDR_RGB: begin
               if (ctrl_autoinc) begin
                  if (pos_x == POS_W'(X_MAX)) begin
                     pos_x <= '0;
                     pos_y <= (pos_y == POS_W'(Y_MAX)) ? '0 : pos_y + 1'b1;
                  end else begin
                     pos_x <= pos_x + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign burst_start = (burst_state == BURST_IDLE) && avs_cmd_read &&
                        avs_cmd_beginbursttransfer && (avs_cmd_burstcount > 10'd1);
   assign rd_fire = (burst_state == BURST_RUN) || avs_cmd_read;
   assign rd_gate = (burst_state == BURST_RUN) || avs_cmd_byteenable[0];
   assign rd_addr = (burst_state == BURST_RUN) ? burst_addr : avs_cmd_address;

   always_comb begin
      rd_word = '0;
      case (rd_addr)
         ADDR_VER0:   rd_word = {8'h00, VER_MAJOR};
         ADDR_VER1:   rd_word = {8'h00, VER_MINOR};
         ADDR_VER2:   rd_word = {8'h00, VER_REV};
         ADDR_VER3:   rd_word = {8'h00, VER_BUILD};
         ADDR_STATUS: rd_word = {fill_sat, 6'b0, fifo_full, fifo_empty};
         ADDR_CTRL:   rd_word = {14'b0, ctrl_autoinc, ctrl_enable};
         ADDR_GAP:    rd_word = gap;
         ADDR_POSX:   rd_word = 16'(pos_x);
         ADDR_POSY:   rd_word = 16'(pos_y);
         default:     rd_word = '0;
      endcase
   end

   always_comb begin
      burst_next = burst_state;
      case (burst_state)
         BURST_IDLE: if (burst_start) burst_next = BURST_RUN;
         BURST_RUN:  if (burst_left == 10'd1) burst_next = BURST_IDLE;
         default:    burst_next = BURST_IDLE;
      endcase
   end

   // The first burst word leaves with the request; the rest stream from burst_addr.
   always_ff @(posedge csi_cmd_clock_clk) begin
      if (rsi_cmd_reset_reset) begin
         burst_state           <= BURST_IDLE;
         burst_addr            <= '0;
         burst_left            <= '0;
         avs_cmd_readdata      <= '0;
         avs_cmd_readdatavalid <= 1'b0;
      end else begin
         burst_state           <= burst_next;
         avs_cmd_readdatavalid <= rd_fire;
         if (rd_fire) begin
            avs_cmd_readdata <= rd_gate ? rd_word : '0;
         end
         if (burst_start) begin
            burst_addr <= avs_cmd_address + 16'd1;
            burst_left <= avs_cmd_burstcount - 10'd1;
         end else if (burst_state == BURST_RUN) begin
            burst_addr <= burst_addr + 16'd1;
            burst_left <= burst_left - 10'd1;
         end
      end
   end

   always_comb begin
      drain_next        = drain_state;
      fifo_pop          = 1'b0;
      coe_dpm_ul1Update = 1'b0;
      case (drain_state)
         DRAIN_IDLE: begin
            if (ctrl_enable && !fifo_empty) begin
               fifo_pop   = 1'b1;
               drain_next = DRAIN_EMIT;
            end
         end
         DRAIN_EMIT: begin
            coe_dpm_ul1Update = 1'b1;
            drain_next        = (gap != 16'd0) ? DRAIN_HOLD : DRAIN_IDLE;
         end
         DRAIN_HOLD: begin
            if (hold_cnt <= 16'd1) drain_next = DRAIN_IDLE;
         end
         default: drain_next = DRAIN_IDLE;
      endcase
   end

   // The popped head entry is captured on the IDLE->EMIT edge and held until the next pop.
   always_ff @(posedge csi_cmd_clock_clk) begin
      if (rsi_cmd_reset_reset) begin
         drain_state       <= DRAIN_IDLE;
         hold_cnt          <= '0;
         coe_dpm_ulPosX    <= '0;
         coe_dpm_ulPosY    <= '0;
         coe_dpm_ulRgbData <= '0;
      end else begin
         drain_state <= drain_next;
         if (drain_state == DRAIN_EMIT) begin
            hold_cnt <= gap;
         end else if (drain_state == DRAIN_HOLD) begin
            hold_cnt <= hold_cnt - 16'd1;
         end
         if (fifo_pop) begin
            coe_dpm_ulPosX    <= fifo_rd_data[ENTRY_W-1 -: POS_W];
            coe_dpm_ulPosY    <= fifo_rd_data[RGB_W +: POS_W];
            coe_dpm_ulRgbData <= fifo_rd_data[RGB_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_drawpoint_mm_bridge.sv
// Scoreboard bench for drawpoint_mm_bridge: expected read words and points are
// queued when driven and compared when readdatavalid / Update appear.
module tb_drawpoint_mm_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] address;
   logic        read;
   logic [15:0] readdata;
   logic        readdatavalid;
   logic        write;
   logic [15:0] writedata;
   logic [1:0]  byteenable;
   logic        beginBurst;
   logic [9:0]  burstCount;
   logic        waitrequest;
   logic        dpmClock;
   logic        dpmReset_n;
   logic        update;
   logic [8:0]  posX;
   logic [8:0]  posY;
   logic [11:0] rgbData;

   typedef struct {
      logic [15:0] data;
      int          due;
   } rd_exp_t;

   typedef struct {
      int x;
      int y;
      int rgb;
   } pt_t;

   rd_exp_t readQ[$];
   pt_t     pointQ[$];
   rd_exp_t re;
   pt_t     pt;

   int vectorCount = 0;
   int missCount   = 0;
   int cyc         = 0;
   int updCount    = 0;
   int prevUpdCyc  = -1;
   int lastSpacing = 0;
   int modelX      = 0;
   int modelY      = 0;
   bit modelAuto   = 1'b0;
   int baseCount;
   int guard;

   drawpoint_mm_bridge dut (
      .csi_cmd_clock_clk          (clk),
      .rsi_cmd_reset_reset        (reset),
      .avs_cmd_address            (address),
      .avs_cmd_read               (read),
      .avs_cmd_readdata           (readdata),
      .avs_cmd_readdatavalid      (readdatavalid),
      .avs_cmd_write              (write),
      .avs_cmd_writedata          (writedata),
      .avs_cmd_byteenable         (byteenable),
      .avs_cmd_beginbursttransfer (beginBurst),
      .avs_cmd_burstcount         (burstCount),
      .avs_cmd_waitrequest        (waitrequest),
      .coe_dpm_ul1Clock           (dpmClock),
      .coe_dpm_ul1Reset_n         (dpmReset_n),
      .coe_dpm_ul1Update          (update),
      .coe_dpm_ulPosX             (posX),
      .coe_dpm_ulPosY             (posY),
      .coe_dpm_ulRgbData          (rgbData)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [15:0] verWord(input int a);
      case (a)
         0:       return 16'h0002;
         3:       return 16'h0001;
         default: return 16'h0000;
      endcase
   endfunction

   // Independent model of the staging registers and the raster auto-increment.
   task automatic modelWrite(input logic [15:0] addr, input logic [15:0] data);
      pt_t p;
      case (addr)
         16'h0005: begin
            modelAuto = data[1];
            if (data[2]) pointQ.delete();
         end
         16'h0008: modelX = int'(data[8:0]);
         16'h0009: modelY = int'(data[8:0]);
         16'h000A: begin
            p.x = modelX;
            p.y = modelY;
            p.rgb = int'(data[11:0]);
            pointQ.push_back(p);
            if (modelAuto) begin
               if (modelX == 319) begin
                  modelX = 0;
                  modelY = (modelY == 239) ? 0 : modelY + 1;
               end else begin
                  modelX = modelX + 1;
               end
            end
         end
         default: ;
      endcase
   endtask

   task automatic applyStimulus(input bit isRead, input logic [15:0] addr, input logic [15:0] data, input int burst);
      int words;
      int g;
      address    = addr;
      byteenable = 2'b11;
      if (isRead) begin
         words      = (burst > 1) ? burst : 1;
         read       = 1'b1;
         beginBurst = (burst > 1);
         burstCount = 10'(words);
         for (int i = 0; i < words; i++) begin
            rd_exp_t e;
            e.data = (burst > 1) ? verWord(int'(addr) + i) : data;
            e.due  = cyc + 1 + i;
            readQ.push_back(e);
         end
         @(posedge clk); #1;
         read       = 1'b0;
         beginBurst = 1'b0;
         burstCount = 10'd1;
         repeat (words + 1) @(posedge clk);
         #1;
      end else begin
         writedata = data;
         write     = 1'b1;
         g         = 0;
         @(negedge clk);
         while (waitrequest && g < 200) begin
            @(negedge clk);
            g++;
         end
         if (g >= 200) checkOutput("wr_stall_timeout", 1, 0);
         @(posedge clk); #1;
         write = 1'b0;
         if (g < 200) modelWrite(addr, data);
      end
   endtask

   task automatic waitDrain();
      int g = 0;
      while (pointQ.size() > 0 && g < 500) begin
         @(posedge clk);
         g++;
      end
      if (g >= 500) checkOutput("drain_timeout", 32'(pointQ.size()), 0);
      #1;
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (readdatavalid) begin
            if (readQ.size() == 0) begin
               checkOutput("rdv_unexpected", 1, 0);
            end else begin
               re = readQ.pop_front();
               checkOutput("rd_data", 32'(readdata), 32'(re.data));
               checkOutput("rd_latency", cyc, re.due);
            end
         end
         if (update) begin
            updCount++;
            if (prevUpdCyc >= 0) begin
               lastSpacing = cyc - prevUpdCyc;
               checkOutput("upd_single_cycle", 32'(lastSpacing >= 2), 1);
            end
            prevUpdCyc = cyc;
            if (pointQ.size() == 0) begin
               checkOutput("upd_unexpected", 1, 0);
            end else begin
               pt = pointQ.pop_front();
               checkOutput("upd_x", 32'(posX), pt.x);
               checkOutput("upd_y", 32'(posY), pt.y);
               checkOutput("upd_rgb", 32'(rgbData), pt.rgb);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      address    = '0;
      read       = 1'b0;
      write      = 1'b0;
      writedata  = '0;
      byteenable = 2'b11;
      beginBurst = 1'b0;
      burstCount = 10'd1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_update", 32'(update), 0);
      checkOutput("rst_posx", 32'(posX), 0);
      checkOutput("rst_rgb", 32'(rgbData), 0);
      checkOutput("rst_readdata", 32'(readdata), 0);
      checkOutput("rst_rdv", 32'(readdatavalid), 0);
      checkOutput("rst_reset_n", 32'(dpmReset_n), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("run_reset_n", 32'(dpmReset_n), 1);
      @(posedge clk); #1;

      // Version, status and unmapped reads, then a 4-word burst.
      applyStimulus(1, 16'h0000, 16'h0002, 1);
      applyStimulus(1, 16'h0004, 16'h0001, 1);
      applyStimulus(1, 16'h0007, 16'h0000, 1);
      applyStimulus(1, 16'h0000, 16'h0000, 4);

      // Single point with no pacing.
      applyStimulus(0, 16'h0005, 16'h0001, 0);
      applyStimulus(0, 16'h0006, 16'h0000, 0);
      applyStimulus(0, 16'h0008, 16'd5, 0);
      applyStimulus(0, 16'h0009, 16'd7, 0);
      applyStimulus(0, 16'h000A, 16'h0ABC, 0);
      waitDrain();
      applyStimulus(1, 16'h0004, 16'h0001, 1);
      applyStimulus(1, 16'h0008, 16'd5, 1);
      applyStimulus(1, 16'h0005, 16'h0001, 1);

      // Raster wrap at the bottom-right corner while disabled.
      applyStimulus(0, 16'h0005, 16'h0002, 0);
      applyStimulus(0, 16'h0008, 16'd318, 0);
      applyStimulus(0, 16'h0009, 16'd239, 0);
      applyStimulus(0, 16'h000A, 16'h0111, 0);
      applyStimulus(0, 16'h000A, 16'h0222, 0);
      applyStimulus(0, 16'h000A, 16'h0333, 0);
      applyStimulus(1, 16'h0004, 16'h0300, 1);
      applyStimulus(1, 16'h0008, 16'd1, 1);
      applyStimulus(1, 16'h0009, 16'd0, 1);
      applyStimulus(0, 16'h0005, 16'h0003, 0);
      waitDrain();

      // Fill the FIFO, see the 17th write stall, then let one drain.
      applyStimulus(0, 16'h0005, 16'h0000, 0);
      for (int i = 0; i < 16; i++) applyStimulus(0, 16'h000A, 16'(16'h0100 + i), 0);
      applyStimulus(1, 16'h0004, 16'h1002, 1);
      address   = 16'h000A;
      writedata = 16'h01FF;
      write     = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("wr_full_stall", 32'(waitrequest), 1);
      end
      @(posedge clk); #1;
      write = 1'b0;
      applyStimulus(0, 16'h0005, 16'h0001, 0);
      applyStimulus(0, 16'h000A, 16'h01FF, 0);
      waitDrain();

      // Flush while disabled drops queued points; flush reads back as 0.
      applyStimulus(0, 16'h0005, 16'h0000, 0);
      applyStimulus(0, 16'h000A, 16'h0055, 0);
      applyStimulus(0, 16'h000A, 16'h0066, 0);
      applyStimulus(1, 16'h0004, 16'h0200, 1);
      applyStimulus(0, 16'h0005, 16'h0004, 0);
      applyStimulus(1, 16'h0004, 16'h0001, 1);
      applyStimulus(1, 16'h0005, 16'h0000, 1);
      applyStimulus(0, 16'h0005, 16'h0001, 0);
      repeat (10) @(posedge clk);
      #1;

      // Paced drain with GAP=3, then reset in the middle of HOLD.
      applyStimulus(0, 16'h0005, 16'h0000, 0);
      applyStimulus(0, 16'h0006, 16'd3, 0);
      applyStimulus(0, 16'h000A, 16'h0AAA, 0);
      applyStimulus(0, 16'h000A, 16'h0BBB, 0);
      applyStimulus(0, 16'h000A, 16'h0CCC, 0);
      baseCount = updCount;
      applyStimulus(0, 16'h0005, 16'h0001, 0);
      guard = 0;
      while (updCount < baseCount + 2 && guard < 100) begin
         @(posedge clk);
         guard++;
      end
      if (guard >= 100) checkOutput("gap_timeout", 32'(updCount - baseCount), 2);
      checkOutput("gap_spacing", lastSpacing, 5);
      #1;
      reset = 1'b1;
      pointQ.delete();
      readQ.delete();
      prevUpdCyc = -1;
      modelX     = 0;
      modelY     = 0;
      modelAuto  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("midhold_rst_update", 32'(update), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (8) begin
         @(negedge clk);
         checkOutput("post_rst_update", 32'(update), 0);
      end
      @(posedge clk); #1;
      applyStimulus(1, 16'h0004, 16'h0001, 1);
      applyStimulus(1, 16'h0005, 16'h0000, 1);
      applyStimulus(1, 16'h0006, 16'h0000, 1);

      repeat (5) @(posedge clk);
      checkOutput("readq_drained", 32'(readQ.size()), 0);
      checkOutput("pointq_drained", 32'(pointQ.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/drawpoint_mm_bridge.md
Name: drawpoint_mm_bridge

Overview:
- Parametrised successor to the DrawPoint master interface.
- Avalon-MM 16-bit slave on the command side: version registers, control/status registers and point-staging registers.
- Written points are queued in a FIFO and replayed on the DrawPoint master port as single-cycle update strobes, with programmable pacing and optional raster auto-increment.
- Sits between the system interconnect and the DrawPoint frame-writer.

Parameters:
- POS_W, 9: X/Y coordinate width; legal range 1..16.
- RGB_W, 12: pixel colour width; legal range 1..16.
- FIFO_DEPTH, 16: point FIFO entries; power of two, minimum 2.
- X_MAX, 319: last X before auto-increment wraps.
- Y_MAX, 239: last Y before auto-increment wraps.
- VER_MAJOR, 8'h02: build identity; VER_MINOR, VER_REV and VER_BUILD default 8'h00, 8'h00, 8'h01.

Ports:
- csi_cmd_clock_clk  in  1  sole clock; also forwarded as coe_dpm_ul1Clock.
- rsi_cmd_reset_reset  in  1  synchronous, active-high reset.
- avs_cmd_address  in  16  word address.
- avs_cmd_read  in  1  read request.
- avs_cmd_readdata  out  16  read data.
- avs_cmd_readdatavalid  out  1  read data qualifier.
- avs_cmd_write  in  1  write request.
- avs_cmd_writedata  in  16  write data.
- avs_cmd_byteenable  in  2  byte enables; bit0 gates all accesses.
- avs_cmd_beginbursttransfer  in  1  burst start.
- avs_cmd_burstcount  in  10  burst length in words.
- avs_cmd_waitrequest  out  1  stall.
- coe_dpm_ul1Clock  out  1  equals csi_cmd_clock_clk.
- coe_dpm_ul1Reset_n  out  1  inverse of rsi_cmd_reset_reset.
- coe_dpm_ul1Update  out  1  one-cycle point strobe.
- coe_dpm_ulPosX  out  POS_W  point X.
- coe_dpm_ulPosY  out  POS_W  point Y.
- coe_dpm_ulRgbData  out  RGB_W  point colour.

Behaviour:
- Register map:
  - 0x0..0x3: version registers, RO. Data is {8'h00, VER_*}.
  - 0x4 STATUS, RO: [0] empty, [1] full, [15:8] fill level (saturates at 255).
  - 0x5 CTRL, RW: [0] enable, [1] autoinc, [2] flush (self-clearing, reads 0). Reset value 0.
  - 0x6 GAP, RW, 16 bit: minimum idle cycles between updates. Reset value 0.
  - 0x8 POSX, RW. 0x9 POSY, RW. Both are POS_W bits, zero-extended on read.
  - 0xA RGB, WO: a write pushes {POSX, POSY, wdata[RGB_W-1:0]} into the FIFO.
- Unmapped reads return 0 with readdatavalid asserted. Unmapped writes are ignored.
- Read latency is exactly 1 cycle. readdatavalid pulses for one cycle per word.
- Burst read, started when beginbursttransfer=1 and burstcount>1:
  - Returns burstcount words on consecutive cycles at address, address+1, and so on.
  - Burst FSM: IDLE -> RUN on burst start; RUN -> IDLE after the last word.
- Burst write: every beat is written to the beat's presented address; there is no internal address increment. Streaming beats to 0xA pushes one point per beat.
- waitrequest is asserted only for a write to 0xA while the FIFO is full. It is purely combinational from full and address. Other accesses never stall.
- Autoinc (CTRL[1]=1): on each accepted RGB push, POSX increments.
  - POSX == X_MAX: POSX <= 0 and POSY increments.
  - POSY == Y_MAX at the same time: POSY <= 0.
  - A same-cycle CPU write to POSX/POSY cannot occur, because the bus is single-ported.
- Drain FSM:
  - States: IDLE, EMIT, HOLD.
  - IDLE -> EMIT when enable=1 and the FIFO is non-empty. Pop in that cycle.
  - EMIT is one cycle: Update=1 with the popped entry registered onto PosX/PosY/Rgb.
  - EMIT -> HOLD if GAP>0; HOLD counts GAP cycles, then returns to IDLE.
  - EMIT -> IDLE directly if GAP=0.
  - With GAP=0, back-to-back strobes are produced: one point per 2 cycles (IDLE+EMIT).
  - Outputs hold their last values between strobes.
- Simultaneous push and pop: level is unchanged. waitrequest still follows the pre-cycle full flag.
- Flush: empties the FIFO the same cycle and wins over a push in that cycle. Flush does not abort an EMIT already in progress.
- Clearing enable: takes effect at the next IDLE decision. The FIFO keeps accepting writes while disabled.
- Reset values:
  - Update=0, PosX/PosY/Rgb=0, readdata=0, readdatavalid=0.
  - FIFO empty, registers 0, both FSMs IDLE.
  - A reset mid-burst abandons the burst and drops the FIFO contents.

Decomposition:
- Package drawpoint_pkg holds:
  - register address constants;
  - burst state enum (IDLE/RUN);
  - drain state enum (IDLE/EMIT/HOLD);
  - CTRL bit index constants.
- Sub-module drawpoint_fifo: synchronous show-ahead FIFO.
  - Parameters: WIDTH = 2*POS_W+RGB_W, DEPTH.
  - Provides: push, pop, flush, full, empty, level.

Test Plan:
- Read 0x0 after reset -> readdata 16'h0002 one cycle later, with readdatavalid=1 for exactly one cycle.
- Burst read, address 0x0, burstcount 4 -> four consecutive valid words 0x0002, 0x0000, 0x0000, 0x0001.
- CTRL=0x1, GAP=0; POSX=5, POSY=7; write RGB 0xABC -> one Update strobe with PosX=5, PosY=7, Rgb=0xABC; STATUS ends at 0x0001.
- CTRL=0x2 (autoinc, disabled); POSX=318, POSY=239; three RGB writes -> queued points (318,239), (319,239), (0,0); enable, then observe the strobes in that order.
- Enable=0; 17 RGB writes with DEPTH=16 -> 17th write sees waitrequest=1 until enable=1 lets one point drain; STATUS full bit =1 before the drain.
- GAP=3, 2 points queued -> consecutive Update strobes 5 cycles apart (EMIT + 3 HOLD + IDLE); assert reset mid-HOLD -> Update=0, STATUS empty.
